// File: rtl/seating_pkg.sv
// Shared types and constants for the seat request front-end and seating controller.
package seating_pkg;

  localparam int unsigned STUDENT_W = 32;
  localparam int unsigned SEAT_W    = 5;
  localparam int unsigned STATE_W   = 2;

  localparam logic [STATE_W-1:0] SEAT_FREE    = 2'd0;
  localparam logic [STATE_W-1:0] SEAT_AWAY    = 2'd1;
  localparam logic [STATE_W-1:0] SEAT_TAKEN   = 2'd2;
  localparam logic [STATE_W-1:0] SEAT_INVALID = 2'd3;

  typedef struct packed {
    logic [STUDENT_W-1:0] student_no;
    logic [SEAT_W-1:0]    seat_no;
    logic [STATE_W-1:0]   seat_state;
  } seat_req_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GAP
  } issue_state_t;

  // Only the three defined seat states may be written; SEAT_INVALID is rejected.
  function automatic logic state_ok(input logic [STATE_W-1:0] s);
    return (s == SEAT_FREE) || (s == SEAT_AWAY) || (s == SEAT_TAKEN);
  endfunction

endpackage

// File: rtl/seat_req_fifo.sv
// Synchronous FIFO of seat requests with occupancy output; head is visible combinationally.
module seat_req_fifo
  import seating_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  seat_req_t                push_data,
  input  logic                     pop,
  output seat_req_t                head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  seat_req_t        mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: pointers and level define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/seat_request_arbiter.sv
// Round-robin kiosk arbiter with request validation, queuing and spaced write issue
// towards the seating controller.
module seat_request_arbiter
  import seating_pkg::*;
#(
  parameter int unsigned NUM_KIOSK = 4,
  parameter int unsigned NUM_SEATS = 32,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned GAP       = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_KIOSK-1:0]            req_valid,
  output logic [NUM_KIOSK-1:0]            req_ready,
  input  logic [NUM_KIOSK*STUDENT_W-1:0]  req_student_no,
  input  logic [NUM_KIOSK*SEAT_W-1:0]     req_seat_no,
  input  logic [NUM_KIOSK*STATE_W-1:0]    req_seat_state,
  input  logic                            hold_off,
  output logic                            write,
  output logic [STUDENT_W-1:0]            student_no,
  output logic [SEAT_W-1:0]               seat_no,
  output logic [STATE_W-1:0]              seat_state,
  output logic                            err_pulse,
  output logic [7:0]                      drop_count,
  output logic [$clog2(DEPTH):0]          fifo_level
);

  localparam int unsigned KW = (NUM_KIOSK > 1) ? $clog2(NUM_KIOSK) : 1;
  localparam int unsigned GW = 4;

  logic [KW-1:0]  rr_ptr;
  logic [KW-1:0]  grant_idx;
  logic           grant;
  seat_req_t      sel;
  logic           sel_bad;
  logic           push;
  logic           pop;
  logic           can_issue;
  logic           gap_done;
  logic [GW-1:0]  gap_cnt;
  seat_req_t      head;
  logic           fifo_full;
  logic           fifo_empty;
  issue_state_t   state;
  issue_state_t   state_nxt;

  function automatic logic [KW-1:0] wrap_idx(input logic [KW-1:0] base, input int unsigned off);
    return KW'((32'(base) + off) % NUM_KIOSK);
  endfunction

  // First valid kiosk at or after the pointer wins; nothing is granted into a full FIFO.
  always_comb begin
    grant     = 1'b0;
    grant_idx = '0;
    req_ready = '0;
    if (rst_n && !fifo_full) begin
      for (int unsigned i = 0; i < NUM_KIOSK; i++) begin
        if (!grant && req_valid[wrap_idx(rr_ptr, i)]) begin
          grant     = 1'b1;
          grant_idx = wrap_idx(rr_ptr, i);
        end
      end
    end
    if (grant) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    sel.student_no = req_student_no[32'(grant_idx)*STUDENT_W +: STUDENT_W];
    sel.seat_no    = req_seat_no[32'(grant_idx)*SEAT_W +: SEAT_W];
    sel.seat_state = req_seat_state[32'(grant_idx)*STATE_W +: STATE_W];
  end

  assign sel_bad = (32'(sel.seat_no) >= NUM_SEATS) || !state_ok(sel.seat_state);
  assign push    = grant && !sel_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      err_pulse  <= 1'b0;
      drop_count <= '0;
    end else begin
      if (grant) rr_ptr <= (32'(grant_idx) == NUM_KIOSK - 1) ? '0 : grant_idx + KW'(1);
      err_pulse <= grant && sel_bad;
      if (grant && sel_bad && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

  seat_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (sel),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign can_issue = !fifo_empty && !hold_off;
  assign gap_done  = (gap_cnt == GW'(GAP - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // The end of a gap re-arbitrates issue directly so bursts run at one write per GAP+1 cycles.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (can_issue) begin
          pop       = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (GAP != 0) begin
          state_nxt = ST_GAP;
        end else begin
          pop       = can_issue;
          state_nxt = can_issue ? ST_ISSUE : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_done) begin
          pop       = can_issue;
          state_nxt = can_issue ? ST_ISSUE : ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt    <= '0;
      write      <= 1'b0;
      student_no <= '0;
      seat_no    <= '0;
      seat_state <= '0;
    end else begin
      gap_cnt <= (state == ST_GAP) ? gap_cnt + GW'(1) : '0;
      write   <= pop;
      if (pop) begin
        student_no <= head.student_no;
        seat_no    <= head.seat_no;
        seat_state <= head.seat_state;
      end
    end
  end

endmodule

// File: tb/tb_seat_request_arbiter.sv
// Randomised and directed bench for seat_request_arbiter against a queue-based model.
module tb_seat_request_arbiter;

  localparam int NK     = 4;
  localparam int NSEATS = 24;
  localparam int DEPTH  = 8;
  localparam int GAP    = 1;

  logic              clk;
  logic              rst_n;
  logic [NK-1:0]     req_valid;
  logic [NK-1:0]     req_ready;
  logic [NK*32-1:0]  req_student_no;
  logic [NK*5-1:0]   req_seat_no;
  logic [NK*2-1:0]   req_seat_state;
  logic              hold_off;
  logic              write;
  logic [31:0]       student_no;
  logic [4:0]        seat_no;
  logic [1:0]        seat_state;
  logic              err_pulse;
  logic [7:0]        drop_count;
  logic [3:0]        fifo_level;

  logic [31:0] d_stu  [NK];
  logic [4:0]  d_seat [NK];
  logic [1:0]  d_st   [NK];

  int tests_run;
  int tests_failed;

  // Model: queued entries, RR pointer, last issue edge, drops, predicted and observed writes.
  logic [38:0] mq[$];
  int          mptr;
  int          mlast;
  int          mdrop;
  logic [38:0] exp_q[$];
  int          exp_cyc[$];
  logic [38:0] obs_q[$];
  int          obs_cyc[$];
  int          edge_cnt;
  int          err_seen;

  seat_request_arbiter #(.NUM_KIOSK(NK), .NUM_SEATS(NSEATS), .DEPTH(DEPTH), .GAP(GAP)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_student_no (req_student_no),
    .req_seat_no    (req_seat_no),
    .req_seat_state (req_seat_state),
    .hold_off       (hold_off),
    .write          (write),
    .student_no     (student_no),
    .seat_no        (seat_no),
    .seat_state     (seat_state),
    .err_pulse      (err_pulse),
    .drop_count     (drop_count),
    .fifo_level     (fifo_level)
  );

  for (genvar i = 0; i < NK; i++) begin : g_pack
    assign req_student_no[i*32 +: 32] = d_stu[i];
    assign req_seat_no[i*5 +: 5]      = d_seat[i];
    assign req_seat_state[i*2 +: 2]   = d_st[i];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && write === 1'b1) begin
      obs_q.push_back({student_no, seat_no, seat_state});
      obs_cyc.push_back(edge_cnt);
    end
    if (rst_n && err_pulse === 1'b1) err_seen++;
  end

  function automatic bit bad_req(input logic [4:0] s, input logic [1:0] t);
    return (int'(s) >= NSEATS) || (t == 2'd3);
  endfunction

  function automatic logic [NK-1:0] model_ready();
    if (mq.size() >= DEPTH) return '0;
    for (int i = 0; i < NK; i++) begin
      if (req_valid[(mptr + i) % NK]) return NK'(1) << ((mptr + i) % NK);
    end
    return '0;
  endfunction

  // One clock edge: issue decision from pre-edge queue, then the arbitrated transfer.
  task automatic tick();
    logic [NK-1:0] g;
    int k;
    @(posedge clk);
    g = model_ready();
    if (mq.size() > 0 && !hold_off && (edge_cnt - mlast) >= GAP + 1) begin
      exp_q.push_back(mq.pop_front());
      exp_cyc.push_back(edge_cnt + 1);
      mlast = edge_cnt;
    end
    k = -1;
    for (int i = 0; i < NK; i++) if (g[i]) k = i;
    if (k >= 0) begin
      if (bad_req(d_seat[k], d_st[k])) begin
        if (mdrop < 255) mdrop++;
      end else begin
        mq.push_back({d_stu[k], d_seat[k], d_st[k]});
      end
      mptr = (k + 1) % NK;
    end
    edge_cnt++;
  endtask

  task automatic apply(input logic [NK-1:0] v, input logic h);
    @(negedge clk);
    req_valid = v;
    hold_off  = h;
    #1;
  endtask

  task automatic set_kiosk(input int k, input logic [31:0] s, input logic [4:0] n, input logic [1:0] t);
    d_stu[k]  = s;
    d_seat[k] = n;
    d_st[k]   = t;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      apply('0, 1'b0);
      tick();
    end
  endtask

  task automatic flush();
    obs_q.delete();
    obs_cyc.delete();
    exp_q.delete();
    exp_cyc.delete();
  endtask

  // Called just after a clock edge so reset lands mid-cycle.
  task automatic assert_reset();
    #2;
    rst_n = 1'b0;
    while (exp_cyc.size() > 0 && exp_cyc[exp_cyc.size()-1] >= edge_cnt) begin
      void'(exp_cyc.pop_back());
      void'(exp_q.pop_back());
    end
    mq.delete();
    mptr  = 0;
    mlast = -1000;
    mdrop = 0;
  endtask

  task automatic release_reset();
    repeat (2) begin
      @(posedge clk);
      edge_cnt++;
    end
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = '0;
    hold_off  = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n     = 1'b1;
    req_valid = '0;
    hold_off  = 1'b0;
    for (int i = 0; i < NK; i++) set_kiosk(i, 32'd0, 5'd0, 2'd0);
    #1;
    rst_n     = 1'b0;
    req_valid = '1;
    #1;
    tests_run += 4;
    if (write !== 1'b0 || err_pulse !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_strobes: got write=%b err=%b expected 0 0", write, err_pulse);
    end
    if ({student_no, seat_no, seat_state} !== 39'd0) begin
      tests_failed++;
      $display("FAIL reset_fields: got %h expected 0", {student_no, seat_no, seat_state});
    end
    if (drop_count !== 8'd0 || fifo_level !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_counts: got drop=%0d level=%0d expected 0 0", drop_count, fifo_level);
    end
    if (req_ready !== '0) begin
      tests_failed++;
      $display("FAIL reset_ready: got %b expected 0", req_ready);
    end
    release_reset();
  endtask

  task automatic test_single();
    int t_edge;
    apply(4'b0001, 1'b0);
    set_kiosk(0, 32'd201819186, 5'd1, 2'd2);
    tests_run++;
    if (req_ready !== 4'b0001) begin
      tests_failed++;
      $display("FAIL single_ready: got %b expected 0001", req_ready);
    end
    t_edge = edge_cnt;
    tick();
    idle(6);
    tests_run += 3;
    if (obs_q.size() != 1) begin
      tests_failed++;
      $display("FAIL single_count: got %0d writes expected 1", obs_q.size());
    end else begin
      if (obs_cyc[0] - t_edge != 2) begin
        tests_failed++;
        $display("FAIL single_latency: got %0d edges expected 2", obs_cyc[0] - t_edge);
      end
      if (obs_q[0] !== {32'd201819186, 5'd1, 2'd2}) begin
        tests_failed++;
        $display("FAIL single_data: got %h expected %h", obs_q[0], {32'd201819186, 5'd1, 2'd2});
      end
    end
    if (write !== 1'b0 || student_no !== 32'd201819186 || seat_no !== 5'd1 || seat_state !== 2'd2) begin
      tests_failed++;
      $display("FAIL single_hold: got w=%b %0d/%0d/%0d expected held fields", write, student_no, seat_no, seat_state);
    end
    flush();
  endtask

  task automatic test_all_kiosks();
    logic [NK-1:0] pend;
    assert_reset();
    release_reset();
    pend = '1;
    for (int c = 0; c < NK; c++) begin
      apply(pend, 1'b0);
      for (int k = 0; k < NK; k++) set_kiosk(k, 32'(1000 + k), 5'(k + 3), 2'(k % 3));
      tests_run++;
      if (req_ready !== (NK'(1) << c)) begin
        tests_failed++;
        $display("FAIL all_grant%0d: got %b expected %b", c, req_ready, NK'(1) << c);
      end
      tick();
      pend[c] = 1'b0;
    end
    idle(12);
    tests_run++;
    if (obs_q.size() != NK) begin
      tests_failed++;
      $display("FAIL all_count: got %0d writes expected %0d", obs_q.size(), NK);
    end
    for (int i = 0; i < NK && i < obs_q.size(); i++) begin
      tests_run++;
      if (obs_q[i] !== {32'(1000 + i), 5'(i + 3), 2'(i % 3)} ||
          (i > 0 && obs_cyc[i] - obs_cyc[i-1] != GAP + 1)) begin
        tests_failed++;
        $display("FAIL all_write%0d: got %h@%0d expected %h spaced %0d", i, obs_q[i], obs_cyc[i],
                 {32'(1000 + i), 5'(i + 3), 2'(i % 3)}, GAP + 1);
      end
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests_run++;
      if (obs_q[i] !== exp_q[i] || obs_cyc[i] != exp_cyc[i]) begin
        tests_failed++;
        $display("FAIL all_model%0d: got %h@%0d expected %h@%0d", i, obs_q[i], obs_cyc[i], exp_q[i], exp_cyc[i]);
      end
    end
    flush();
  endtask

  task automatic test_invalid();
    int e0;
    assert_reset();
    release_reset();
    e0 = err_seen;
    for (int r = 0; r < 2; r++) begin
      apply(4'b0100, 1'b0);
      if (r == 0) set_kiosk(2, 32'd42, 5'd30, 2'd1);
      else        set_kiosk(2, 32'd43, 5'd5, 2'd3);
      tests_run++;
      if (req_ready !== 4'b0100) begin
        tests_failed++;
        $display("FAIL invalid_ack%0d: got %b expected 0100", r, req_ready);
      end
      tick();
      tests_run++;
      if (fifo_level !== 4'd0) begin
        tests_failed++;
        $display("FAIL invalid_level%0d: got %0d expected 0", r, fifo_level);
      end
    end
    idle(4);
    tests_run += 2;
    if (err_seen - e0 != 2 || drop_count !== 8'd2 || mdrop != 2) begin
      tests_failed++;
      $display("FAIL invalid_drops: got pulses=%0d drop=%0d expected 2 2", err_seen - e0, drop_count);
    end
    if (obs_q.size() != 0) begin
      tests_failed++;
      $display("FAIL invalid_nowrite: got %0d writes expected 0", obs_q.size());
    end
    // Highest legal seat number is accepted.
    apply(4'b0100, 1'b0);
    set_kiosk(2, 32'd44, 5'(NSEATS - 1), 2'd0);
    tick();
    idle(5);
    tests_run++;
    if (obs_q.size() != 1 || obs_q[0] !== {32'd44, 5'(NSEATS - 1), 2'd0} || drop_count !== 8'd2) begin
      tests_failed++;
      $display("FAIL invalid_boundary: got %0d writes drop=%0d expected 1 write of seat %0d", obs_q.size(), drop_count, NSEATS - 1);
    end
    flush();
  endtask

  task automatic test_hold_full();
    logic [NK-1:0] g;
    int n;
    int cyc;
    for (n = 0; n < DEPTH; n++) begin
      apply(4'b0010, 1'b1);
      set_kiosk(1, 32'(5000 + n), 5'(n), 2'(n % 3));
      tests_run++;
      if (req_ready !== 4'b0010) begin
        tests_failed++;
        $display("FAIL full_fill%0d: got %b expected 0010", n, req_ready);
      end
      tick();
    end
    apply(4'b0010, 1'b1);
    set_kiosk(1, 32'(5000 + n), 5'(n), 2'(n % 3));
    tests_run++;
    if (fifo_level !== 4'(DEPTH) || req_ready !== 4'b0000) begin
      tests_failed++;
      $display("FAIL full_block: got level=%0d ready=%b expected %0d 0000", fifo_level, req_ready, DEPTH);
    end
    tick();
    cyc = 0;
    while (n < 10 && cyc < 100) begin
      apply(4'b0010, 1'b0);
      set_kiosk(1, 32'(5000 + n), 5'(n), 2'(n % 3));
      g = model_ready();
      tests_run++;
      if (req_ready !== g) begin
        tests_failed++;
        $display("FAIL full_drain_ready: got %b expected %b", req_ready, g);
      end
      tick();
      if (g[1]) n++;
      cyc++;
    end
    tests_run++;
    if (n < 10) begin
      tests_failed++;
      $display("FAIL full_timeout: got %0d accepted expected 10", n);
    end
    idle(30);
    tests_run++;
    if (obs_q.size() != 10) begin
      tests_failed++;
      $display("FAIL full_count: got %0d writes expected 10", obs_q.size());
    end
    for (int i = 0; i < 10 && i < obs_q.size(); i++) begin
      tests_run++;
      if (obs_q[i] !== {32'(5000 + i), 5'(i), 2'(i % 3)} || i >= exp_q.size() || obs_cyc[i] != exp_cyc[i]) begin
        tests_failed++;
        $display("FAIL full_write%0d: got %h@%0d expected %h", i, obs_q[i], obs_cyc[i], {32'(5000 + i), 5'(i), 2'(i % 3)});
      end
    end
    flush();
  endtask

  task automatic test_reset_mid_gap();
    assert_reset();
    release_reset();
    for (int i = 0; i < 4; i++) begin
      apply(4'b1000, 1'b1);
      set_kiosk(3, 32'(7000 + i), 5'(i), 2'd1);
      tick();
    end
    apply('0, 1'b0);
    tick();
    apply('0, 1'b1);
    tick();
    assert_reset();
    req_valid = '1;
    #1;
    tests_run += 2;
    if (write !== 1'b0 || {student_no, seat_no, seat_state} !== 39'd0 || err_pulse !== 1'b0) begin
      tests_failed++;
      $display("FAIL gaprst_outputs: got w=%b fields=%h expected 0", write, {student_no, seat_no, seat_state});
    end
    if (fifo_level !== 4'd0 || req_ready !== '0) begin
      tests_failed++;
      $display("FAIL gaprst_queue: got level=%0d ready=%b expected 0 0", fifo_level, req_ready);
    end
    release_reset();
    idle(10);
    tests_run++;
    if (obs_q.size() != 1 || exp_q.size() != 1 || obs_q[0] !== {32'd7000, 5'd0, 2'd1}) begin
      tests_failed++;
      $display("FAIL gaprst_writes: got %0d writes expected only the pre-reset one", obs_q.size());
    end
    flush();
    apply(4'b0001, 1'b0);
    set_kiosk(0, 32'd9999, 5'd9, 2'd2);
    tick();
    idle(4);
    tests_run++;
    if (obs_q.size() != 1 || obs_q[0] !== {32'd9999, 5'd9, 2'd2} || obs_cyc[0] != exp_cyc[0]) begin
      tests_failed++;
      $display("FAIL gaprst_new: got %0d writes expected one of student 9999", obs_q.size());
    end
    flush();
  endtask

  task automatic test_saturation();
    int e0;
    int k;
    assert_reset();
    release_reset();
    e0 = err_seen;
    for (int r = 0; r < 300; r++) begin
      k = $urandom_range(NK - 1, 0);
      apply(NK'(1) << k, 1'b0);
      if (r % 2 == 0) set_kiosk(k, $urandom, 5'($urandom_range(31, NSEATS)), 2'($urandom_range(2, 0)));
      else            set_kiosk(k, $urandom, 5'($urandom_range(31, 0)), 2'd3);
      tick();
    end
    idle(3);
    tests_run += 2;
    if (drop_count !== 8'd255 || mdrop != 255) begin
      tests_failed++;
      $display("FAIL sat_count: got %0d expected 255", drop_count);
    end
    if (err_seen - e0 != 300 || obs_q.size() != 0) begin
      tests_failed++;
      $display("FAIL sat_pulses: got %0d pulses %0d writes expected 300 0", err_seen - e0, obs_q.size());
    end
    flush();
  endtask

  task automatic test_random();
    logic [NK-1:0] pend;
    logic [NK-1:0] fresh;
    logic [NK-1:0] g;
    logic          h;
    assert_reset();
    release_reset();
    pend = '0;
    for (int c = 0; c < 500; c++) begin
      fresh = '0;
      for (int k = 0; k < NK; k++) if (!pend[k] && $urandom_range(1, 0) == 1) fresh[k] = 1'b1;
      pend = pend | fresh;
      h = ($urandom_range(3, 0) == 0);
      apply(pend, h);
      for (int k = 0; k < NK; k++)
        if (fresh[k]) set_kiosk(k, $urandom, 5'($urandom_range(31, 0)), 2'($urandom_range(3, 0)));
      g = model_ready();
      tests_run += 2;
      if (req_ready !== g) begin
        tests_failed++;
        $display("FAIL rand_ready@%0d: got %b expected %b", c, req_ready, g);
      end
      if (fifo_level !== 4'(mq.size())) begin
        tests_failed++;
        $display("FAIL rand_level@%0d: got %0d expected %0d", c, fifo_level, mq.size());
      end
      tick();
      pend = pend & ~g;
    end
    idle(40);
    tests_run += 2;
    if (drop_count !== 8'(mdrop)) begin
      tests_failed++;
      $display("FAIL rand_drops: got %0d expected %0d", drop_count, mdrop);
    end
    if (obs_q.size() != exp_q.size() || mq.size() != 0) begin
      tests_failed++;
      $display("FAIL rand_count: got %0d writes expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests_run++;
      if (obs_q[i] !== exp_q[i] || obs_cyc[i] != exp_cyc[i]) begin
        tests_failed++;
        $display("FAIL rand_write%0d: got %h@%0d expected %h@%0d", i, obs_q[i], obs_cyc[i], exp_q[i], exp_cyc[i]);
      end
    end
    flush();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    edge_cnt     = 0;
    err_seen     = 0;
    mptr         = 0;
    mlast        = -1000;
    mdrop        = 0;
    test_reset();
    test_single();
    test_all_kiosks();
    test_invalid();
    test_hold_full();
    test_reset_mid_gap();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no completion expected finish before 500000");
    $fatal(1);
  end

endmodule
